// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-issue stage: opcodes, instruction
// field positions, buffer occupancy states and the issue-entry payload.
package alu_pkg;

   localparam int OPC_HI      = 31;
   localparam int OPC_LO      = 27;
   localparam int RD_HI       = 26;
   localparam int RD_LO       = 22;
   localparam int RS1_HI      = 21;
   localparam int RS1_LO      = 17;
   localparam int RS2_HI      = 16;
   localparam int RS2_LO      = 12;
   localparam int IMM_SEL_BIT = 11;
   localparam int IMM_HI      = 10;
   localparam int IMM_LO      = 0;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_LSR = 5'b00100;
   localparam logic [4:0] OP_ASR = 5'b00101;
   localparam logic [4:0] OP_SL  = 5'b00110;
   localparam logic [4:0] OP_AND = 5'b01000;
   localparam logic [4:0] OP_OR  = 5'b01001;
   localparam logic [4:0] OP_NOT = 5'b01010;
   localparam logic [4:0] OP_MOV = 5'b01100;
   localparam logic [4:0] OP_POP = 5'b10000;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_FULL  = 2'd2
   } occ_state_t;

   typedef struct packed {
      logic [4:0]  opcode;
      logic [4:0]  rd;
      logic [31:0] alu_a;
      logic [31:0] alu_b;
   } issue_entry_t;

   function automatic logic [31:0] sext_imm11(input logic [10:0] imm);
      return {{21{imm[10]}}, imm};
   endfunction

   function automatic logic is_shift(input logic [4:0] op);
      return (op == OP_LSR) || (op == OP_ASR) || (op == OP_SL);
   endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry ready/valid buffer. in_ready, out_valid and the head entry are all
// registered, so neither handshake side sees a combinational path from the other.
module skid_buf2
   import alu_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output occ_state_t   state
);

   // Handshake: a beat moves on a rising edge where valid && ready on that side.
   logic [W-1:0] slot1;
   logic         push;
   logic         pop;

   assign push = in_valid && in_ready;
   assign pop  = out_valid && out_ready;

   // out_data always holds the oldest entry; slot1 only ever holds the second.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= OCC_EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         slot1     <= '0;
      end else begin
         case (state)
            OCC_EMPTY: begin
               if (push) begin
                  out_data  <= in_data;
                  out_valid <= 1'b1;
                  state     <= OCC_ONE;
               end
            end
            OCC_ONE: begin
               case ({push, pop})
                  2'b10: begin
                     slot1    <= in_data;
                     in_ready <= 1'b0;
                     state    <= OCC_FULL;
                  end
                  2'b01: begin
                     out_valid <= 1'b0;
                     state     <= OCC_EMPTY;
                  end
                  2'b11: out_data <= in_data;
                  default: ;
               endcase
            end
            OCC_FULL: begin
               if (pop) begin
                  out_data <= slot1;
                  in_ready <= 1'b1;
                  state    <= OCC_ONE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state     <= OCC_EMPTY;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_operand_issue.sv
// Operand issue stage: decodes the instruction, picks register, forwarded or
// immediate operands, applies opcode-specific overrides and buffers the result.
module alu_operand_issue
   import alu_pkg::*;
#(
   parameter bit FWD_EN = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        instr,
   input  logic [31:0]        rs1_data,
   input  logic [31:0]        rs2_data,
   input  logic               wb_valid,
   input  logic [4:0]         wb_rd,
   input  logic [31:0]        wb_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4:0]         opcode,
   output logic [4:0]         rd,
   output logic signed [31:0] alu_a,
   output logic signed [31:0] alu_b,
   output logic [31:0]        issue_cnt,
   output occ_state_t         buf_state
);

   logic [4:0]   rs1;
   logic [4:0]   rs2;
   logic         fwd_a;
   logic         fwd_b;
   issue_entry_t in_e;
   issue_entry_t out_e;
   logic [31:0]  cnt_q;

   assign rs1   = instr[RS1_HI:RS1_LO];
   assign rs2   = instr[RS2_HI:RS2_LO];
   assign fwd_a = FWD_EN && wb_valid && (wb_rd == rs1);
   assign fwd_b = FWD_EN && wb_valid && (wb_rd == rs2);

   // Register 0 reads as zero and is never a forwarding target.
   always_comb begin
      in_e.opcode = instr[OPC_HI:OPC_LO];
      in_e.rd     = instr[RD_HI:RD_LO];
      in_e.alu_a  = (rs1 == 5'd0) ? 32'd0 : (fwd_a ? wb_data : rs1_data);
      if (instr[IMM_SEL_BIT])
         in_e.alu_b = sext_imm11(instr[IMM_HI:IMM_LO]);
      else
         in_e.alu_b = (rs2 == 5'd0) ? 32'd0 : (fwd_b ? wb_data : rs2_data);
      if (is_shift(in_e.opcode))
         in_e.alu_b[31:5] = '0;
      if (in_e.opcode == OP_MOV)
         in_e.alu_a = 32'd0;
      if (in_e.opcode == OP_POP)
         in_e.alu_b = 32'd4;
   end

   skid_buf2 #(
      .W($bits(issue_entry_t))
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_e),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_e),
      .state     (buf_state)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else if (out_valid && out_ready)
         cnt_q <= cnt_q + 32'd1;
   end

   assign opcode    = out_e.opcode;
   assign rd        = out_e.rd;
   assign alu_a     = out_e.alu_a;
   assign alu_b     = out_e.alu_b;
   assign issue_cnt = cnt_q;

endmodule

// File: doc/alu_operand_issue.md
ALU_OPERAND_ISSUE -- requirements
Module: alu_operand_issue

Interface
REQ-001 Parameter: FWD_EN, default 1, enables the single writeback forwarding path.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 in_valid  in  1  upstream instruction + register data valid.
REQ-005 in_ready  out  1  stage can accept; transfer when in_valid && in_ready.
REQ-006 instr  in  32  [31:27] opcode, [26:22] rd, [21:17] rs1, [16:12] rs2, [11] imm_sel, [10:0] imm11.
REQ-007 rs1_data, rs2_data  in  32 each  register-file read data for rs1/rs2.
REQ-008 wb_valid, wb_rd, wb_data  in  1/5/32  writeback forwarding source.
REQ-009 out_valid  out  1  ALU operands valid.
REQ-010 out_ready  in  1  ALU side accepts; transfer when out_valid && out_ready.
REQ-011 opcode, rd  out  5/5  pass-through fields to ALU and writeback.
REQ-012 alu_a, alu_b  out  32 signed each  ALU operands.
REQ-013 issue_cnt  out  32  count of completed output transfers.

Function
REQ-014 Operand A: register 0 -> 0; else wb_data if FWD_EN && wb_valid && wb_rd==rs1 && rs1!=0; else rs1_data.
REQ-015 Operand B likewise from rs2 when imm_sel=0; when imm_sel=1, sign-extended imm11.
REQ-016 Shift opcodes (00100 LSR, 00101 ASR, 00110 SL): alu_b[31:5] forced to 0 after selection.
REQ-017 MOV (01100): alu_a forced to 0; POP (10000): alu_b forced to 32'd4 regardless of imm_sel.
REQ-018 Unlisted opcodes pass unchanged; no opcode is rejected.
REQ-019 Operand selection is combinational on input side; results captured at input transfer; latency input transfer -> out_valid = 1 cycle.
REQ-020 Two-entry skid buffer: in_ready = (occupancy < 2), registered, never combinationally dependent on out_ready.
REQ-021 Full throughput: with out_ready held 1, one transfer per cycle, no bubbles.
REQ-022 Order preserved FIFO; output fields stable while out_valid && !out_ready.
REQ-023 Occupancy states EMPTY(0), ONE(1), FULL(2); EMPTY->ONE on in only; ONE->FULL on in without out; FULL->ONE on out; ONE->EMPTY on out without in; simultaneous in+out in ONE stays ONE.
REQ-024 In FULL, in_ready=0; in_valid ignored.
REQ-025 out_valid=1 iff occupancy>0.
REQ-026 issue_cnt increments by 1 per output transfer, wraps 32'hFFFFFFFF -> 0.
REQ-027 Forwarding uses wb signals sampled in the same cycle as the input transfer only; later writebacks do not modify buffered entries.

Reset
REQ-028 On rst assertion, immediately: occupancy EMPTY, out_valid=0, in_ready=1 (after deassertion), issue_cnt=0, opcode/rd/alu_a/alu_b=0.
REQ-029 Reset mid-transfer discards all buffered entries; no partial output after deassertion.
REQ-030 First input transfer possible on first rising edge after rst deasserts.

Structure
REQ-031 Shared package alu_pkg holds opcode localparams (SUB, POP, LSR, ASR, SL, AND, OR, NOT, MOV), instruction field bit positions, and an issue-entry struct {opcode, rd, alu_a, alu_b}.
REQ-032 Single sub-module skid_buf2 (parameterised 2-entry ready/valid buffer) instantiated once; decode/forwarding logic in top.

Verification
REQ-033 Reset then instr ADD rd=3 rs1=1 rs2=2 imm_sel=0, rs1_data=5, rs2_data=7 -> next cycle out_valid=1, opcode=00000, alu_a=5, alu_b=7, rd=3.
REQ-034 imm_sel=1, imm11=11'h7FF, opcode SL -> alu_b=31 (sign-extended FFFFFFFF masked to 5 bits); opcode ADD same imm -> alu_b=32'hFFFFFFFF.
REQ-035 rs1=4, rs1_data=1, wb_valid=1, wb_rd=4, wb_data=99 -> alu_a=99; same with rs1=0, wb_rd=0 -> alu_a=0.
REQ-036 out_ready=0, drive 3 back-to-back valid inputs -> third stalls (in_ready=0 after two accepted); release out_ready -> outputs in order, no loss, no duplication, issue_cnt=3.
REQ-037 Buffer FULL, assert rst mid-cycle -> out_valid=0 and issue_cnt=0 immediately without clock edge.
REQ-038 Preload issue_cnt path to 32'hFFFFFFFF via 2^32-1 transfers (or force) then one transfer -> issue_cnt=0.
